binadd_slice_ctrl: RTL and testbench
====================================

Name: binadd_slice_ctrl

Overview:
- Sequencing controller that performs a WIDTH-bit addition by feeding successive 2-bit slices through the team's existing combinational 2-bit adder, binadd.
- It sits both directly upstream and directly downstream of binadd:
  - drives binadd's a, b and carry-in inputs;
  - consumes binadd's sum and carry-out;
  - registers the inter-slice carry;
  - assembles the full-width result with a start/done handshake.
- One slice per clock, LSB slice first.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and at least 2.
- NSLICE, WIDTH/2, number of 2-bit slices (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled only in IDLE.
- op_a  in  WIDTH  operand A; captured on accepted start.
- op_b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result register.
- cout  out  1  final carry-out.
- ovf  out  1  two's-complement overflow flag.
- sl_a  out  2  slice of A to binadd a.
- sl_b  out  2  slice of B to binadd b.
- sl_c  out  1  running carry to binadd c.
- sl_s  in  2  binadd s.
- sl_cout  in  1  binadd cout.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; slice index=0; carry reg=0;
  - operand regs, sum, cout, ovf, done and busy all 0.
  - Reset mid-operation aborts immediately; no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: on start=1 at a rising edge. Latches op_a, op_b into internal regs, carry reg <= cin, idx <= 0.
  - RUN -> RUN: when idx < NSLICE-1. Each edge: sum[2*idx+:2] <= sl_s; carry <= sl_cout; idx <= idx+1.
  - RUN -> DONE: at the edge that captures slice NSLICE-1. Same capture as above; cout <= sl_cout; ovf computed.
  - DONE -> IDLE: unconditionally after one cycle.
- Slice bus:
  - In RUN: sl_a = a_reg[2*idx+:2], sl_b = b_reg[2*idx+:2], sl_c = carry reg. These are registered-source combinational outputs.
  - Outside RUN: sl_a, sl_b and sl_c are driven 0.
- binadd is purely combinational, so one slice completes per cycle.
- Latency: start accepted at edge E0; slices captured at E1..E_NSLICE; done is high for exactly the cycle following E_NSLICE. That is NSLICE+1 cycles from start to done (5 for WIDTH=8).
- busy is a registered output, high from the cycle after E0 through the done cycle inclusive.
- done is high only in DONE state.
- sum, cout and ovf:
  - hold their values until the next accepted start;
  - sum is cleared to 0 when start is accepted.
- ovf = (a_reg[MSB]==b_reg[MSB]) && (final sum[MSB]!=a_reg[MSB]); computed at the final capture edge.
- start while busy (RUN or DONE) is ignored; the operands are not re-latched.
- start held high continuously: a new operation begins in the IDLE cycle after DONE, giving back-to-back throughput of one op per NSLICE+2 cycles.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of op_a+op_b+cin.

Decomposition:
- Shared package binadd_pkg contains:
  - SLICE_W=2 constant;
  - state enum {IDLE, RUN, DONE};
  - index width localparam via $clog2(NSLICE).
- No sub-module inside this block. binadd is instantiated beside it at the parent level and wired sl_a/sl_b/sl_c -> a/b/c and s/cout -> sl_s/sl_cout. The bench instantiates both.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0 -> done 5 cycles after start; sum=0x96, cout=0, ovf=1; sl_a sequence 2,2,1,1.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Carry ripples through all 4 slices (sl_c = 0,1,1,1).
- op_a=0x80, op_b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
- Start 0x12+0x34, then pulse start with 0xFF/0xFF during RUN -> ignored; sum=0x46, cout=0, exactly one done pulse.
- Assert rst_n=0 asynchronously mid-RUN (between edges) -> busy, done, sum, sl_* go 0 immediately; no done pulse; a fresh start then yields a correct result.
- Exhaustive sweep (WIDTH=4): all op_a, op_b in 0..15 with cin in {0,1}, start held high -> every {cout,sum} equals op_a+op_b+cin; ovf matches the signed reference model.

Source files
------------

// File: rtl/binadd_pkg.sv
// Shared definitions for the sliced 2-bit adder controller.
// Holds the slice width, the controller state encoding and the index-width helper.
// Imported by binadd_slice_ctrl; binadd itself needs nothing from here.
package binadd_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that walks nslice slices; never narrower than one bit
  // so a single-slice build still has a legal index register.
  function automatic int idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/binadd.sv
// Combinational 2-bit full adder: {cout, s} = a + b + c.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow inputs continuously.
// Ports: a, b (2-bit addends), c (carry-in), s (2-bit sum), cout (carry-out).
module binadd (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       c,
  output logic [1:0] s,
  output logic       cout
);

  assign {cout, s} = 3'(a) + 3'(b) + 3'(c);

endmodule

// File: rtl/binadd_slice_ctrl.sv
// Sequences a WIDTH-bit add through an external 2-bit binadd, one slice per clock, LSB first.
// Latency: start accepted at edge E0, done pulses in the cycle after E_NSLICE (NSLICE+1 cycles).
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
// Ports: clk/rst_n; start, op_a, op_b, cin request; busy, done, sum, cout, ovf result;
//        sl_a/sl_b/sl_c drive binadd a/b/c, sl_s/sl_cout return binadd s/cout.
module binadd_slice_ctrl
  import binadd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NSLICE = WIDTH / SLICE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               ovf,
  output logic [SLICE_W-1:0] sl_a,
  output logic [SLICE_W-1:0] sl_b,
  output logic               sl_c,
  input  logic [SLICE_W-1:0] sl_s,
  input  logic               sl_cout
);

  localparam int               IDX_W    = idx_w(NSLICE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("binadd_slice_ctrl: WIDTH must be even and at least 2");
  end

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic             accept;
  logic             last_slice;

  assign last_slice = (state == RUN) && (idx == IDX_LAST);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN:     if (idx == IDX_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice bus is only live in RUN so binadd sees a quiet zero input otherwise.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    sl_c = 1'b0;
    if (state == RUN) begin
      sl_a = a_reg[SLICE_W*idx +: SLICE_W];
      sl_b = b_reg[SLICE_W*idx +: SLICE_W];
      sl_c = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      // busy and done are registered copies of where the FSM is heading,
      // so they line up exactly with the RUN/DONE cycles.
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      if (accept) begin
        a_reg <= op_a;
        b_reg <= op_b;
        carry <= cin;
        idx   <= '0;
        sum   <= '0;
      end else if (state == RUN) begin
        sum[SLICE_W*idx +: SLICE_W] <= sl_s;
        carry                       <= sl_cout;
        idx                         <= idx + 1'b1;
        if (last_slice) begin
          cout <= sl_cout;
          // Final sum MSB is sl_s[1] on this edge; sum[] has not updated yet.
          ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sl_s[SLICE_W-1] != a_reg[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_binadd_slice_ctrl.sv
module tb_binadd_slice_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit controller + adder
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] op_a8, op_b8, sum8;
  logic [1:0] sla8, slb8, sls8;
  logic       slc8, slcout8;

  // 4-bit controller + adder
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] op_a4, op_b4, sum4;
  logic [1:0] sla4, slb4, sls4;
  logic       slc4, slcout4;

  binadd_slice_ctrl #(.WIDTH(8)) u_ctrl8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(op_a8), .op_b(op_b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .sl_a(sla8), .sl_b(slb8), .sl_c(slc8), .sl_s(sls8), .sl_cout(slcout8)
  );
  binadd u_add8 (.a(sla8), .b(slb8), .c(slc8), .s(sls8), .cout(slcout8));

  binadd_slice_ctrl #(.WIDTH(4)) u_ctrl4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_a(op_a4), .op_b(op_b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .sl_a(sla4), .sl_b(slb4), .sl_c(slc4), .sl_s(sls4), .sl_cout(slcout4)
  );
  binadd u_add4 (.a(sla4), .b(slb4), .c(slc4), .s(sls4), .cout(slcout4));

  int ncmp  = 0;
  int nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic int ref_sum(input int w, input int a, input int b, input int c);
    return (a + b + c) % (1 << w);
  endfunction

  function automatic int ref_cout(input int w, input int a, input int b, input int c);
    return (a + b + c) >> w;
  endfunction

  function automatic int to_signed(input int w, input int v);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic int ref_ovf(input int w, input int a, input int b, input int c);
    int s;
    s = to_signed(w, a) + to_signed(w, b) + c;
    return ((s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)))) ? 1 : 0;
  endfunction

  // Carry entering slice k: the carry out of the low 2k bits of the sum.
  function automatic int ref_carry_in(input int k, input int a, input int b, input int c);
    int m;
    m = 1 << (2 * k);
    return ((a % m) + (b % m) + c) / m;
  endfunction

  task automatic do_op8(input int a, input int b, input int c, input bit poke);
    int         n;
    int         dones;
    bit         busy_ok;
    logic [7:0] oa, ob;
    logic [3:0] oc, ec;
    oa = '0; ob = '0; oc = '0; busy_ok = 1'b1;
    @(negedge clk);
    op_a8 = a[7:0]; op_b8 = b[7:0]; cin8 = c[0]; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 20) begin
      if (n <= 4) begin
        oa[2*(n-1) +: 2] = sla8;
        ob[2*(n-1) +: 2] = slb8;
        oc[n-1]          = slc8;
      end
      busy_ok &= busy8;
      if (poke && n == 2) begin start8 = 1'b1; op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b1; end
      if (poke && n == 3) begin start8 = 1'b0; op_a8 = a[7:0]; op_b8 = b[7:0]; cin8 = c[0]; end
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) ec[k] = ref_carry_in(k, a, b, c) != 0;
    check("latency", n, 5);
    check("done_hi", done8, 1);
    check("busy_in_done", busy8, 1);
    check("busy_in_run", busy_ok, 1);
    check("sum", sum8, ref_sum(8, a, b, c));
    check("cout", cout8, ref_cout(8, a, b, c));
    check("ovf", ovf8, ref_ovf(8, a, b, c));
    check("sl_a_seq", oa, a[7:0]);
    check("sl_b_seq", ob, b[7:0]);
    check("sl_c_seq", oc, ec);
    @(negedge clk);
    check("done_pulse_end", done8, 0);
    check("busy_idle", busy8, 0);
    check("sl_idle", {sla8, slb8, slc8}, 0);
    dones = 0;
    repeat (3) begin
      if (done8) dones++;
      @(negedge clk);
    end
    check("no_extra_done", dones, 0);
    check("sum_hold", sum8, ref_sum(8, a, b, c));
  endtask

  initial begin
    int dones;
    int n;
    int a, b, c;
    rst_n = 1'b1;
    start8 = 1'b0; cin8 = 1'b0; op_a8 = '0; op_b8 = '0;
    start4 = 1'b0; cin4 = 1'b0; op_a4 = '0; op_b4 = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout_ovf", {cout8, ovf8}, 0);
    check("rst_sl", {sla8, slb8, slc8}, 0);
    check("rst_sum4", {busy4, done4, sum4}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op8(32'h5A, 32'h3C, 0, 1'b0);
    do_op8(32'hFF, 32'h01, 0, 1'b0);
    do_op8(32'h80, 32'h80, 1, 1'b0);
    do_op8(32'h12, 32'h34, 0, 1'b1);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    op_a8 = 8'h12; op_b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy8, 0);
    check("arst_done", done8, 0);
    check("arst_sum", sum8, 0);
    check("arst_sl", {sla8, slb8, slc8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("arst_no_done", dones, 0);
    do_op8(32'h12, 32'h34, 0, 1'b0);

    // Random operands
    repeat (40) begin
      do_op8($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(1, 0), 1'b0);
    end

    // Exhaustive 4-bit sweep with start held high
    @(negedge clk);
    op_a4 = 4'd0; op_b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      a = i & 15; b = (i >> 4) & 15; c = i >> 8;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done4 && n < 12);
      check("sw_period", n, (i == 0) ? 3 : 4);
      check("sw_result", {cout4, sum4}, a + b + c);
      check("sw_ovf", ovf4, ref_ovf(4, a, b, c));
      if (i < 511) begin
        op_a4 = 4'((i + 1) & 15);
        op_b4 = 4'(((i + 1) >> 4) & 15);
        cin4  = ((i + 1) >> 8) != 0;
      end
    end
    start4 = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
